// File: rtl/capture_readback_pkg.sv
// Shared types and constants for the capture readback path: FSM state
// encoding, bytes-per-sample helper and the ACK timeout.
package acsp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MEMWAIT,
    SEND,
    ACK,
    DRAIN,
    FINISH
  } readback_state_t;

  localparam int ACK_TIMEOUT = 4;

  function automatic int bytes_per_sample(input int sample_width);
    return (sample_width + 7) / 8;
  endfunction

endpackage

// File: rtl/capture_readback_byte_serializer.sv
// Splits one sample word into bytes LSB first and paces each byte against
// the UART busy handshake, with a timeout for UARTs that never show busy.
module byte_serializer
  import acsp_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    abort_i,
  input  logic                    load_i,
  input  logic [SAMPLE_WIDTH-1:0] word_i,
  input  logic                    tx_busy_i,
  output logic [7:0]              tx_data_o,
  output logic                    tx_start_o,
  output logic                    byte_done_o,
  output logic                    last_byte_o
);

  localparam int BPS  = bytes_per_sample(SAMPLE_WIDTH);
  localparam int SW   = BPS * 8;
  localparam int IDXW = (BPS > 1) ? $clog2(BPS) : 1;

  readback_state_t sub_q, sub_d;
  logic [SW-1:0]   sreg_q, sreg_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [2:0]      timer_q, timer_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;

  assign last_byte_o = (idx_q == IDXW'(BPS - 1));
  assign tx_data_o   = tx_data_q;
  assign tx_start_o  = tx_start_q;

  always_comb begin
    sub_d       = sub_q;
    sreg_d      = sreg_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    byte_done_o = 1'b0;
    if (abort_i) begin
      sub_d = IDLE;
    end else if (load_i) begin
      sreg_d                   = '0;
      sreg_d[SAMPLE_WIDTH-1:0] = word_i;
      idx_d                    = '0;
      sub_d                    = SEND;
    end else begin
      case (sub_q)
        SEND: begin
          if (!tx_busy_i) begin
            tx_data_d  = sreg_q[7:0];
            tx_start_d = 1'b1;
            timer_d    = '0;
            sub_d      = ACK;
          end
        end
        ACK: begin
          // A UART that completes instantly never shows busy; give up after the timeout.
          if (tx_busy_i || (timer_q == 3'(ACK_TIMEOUT - 1))) begin
            sub_d = DRAIN;
          end else begin
            timer_d = timer_q + 3'd1;
          end
        end
        DRAIN: begin
          if (!tx_busy_i) begin
            byte_done_o = 1'b1;
            if (last_byte_o) begin
              sub_d = IDLE;
            end else begin
              sreg_d = sreg_q >> 8;
              idx_d  = idx_q + 1'b1;
              sub_d  = SEND;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sub_q      <= IDLE;
      sreg_q     <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      sub_q      <= sub_d;
      sreg_q     <= sreg_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

endmodule

// File: rtl/capture_readback.sv
// Streams a completed capture to the host newest-to-oldest; this FSM owns the
// RAM address, remaining sample count and the done pulse.
module capture_readback
  import acsp_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_WIDTH-1:0]   newest_addr,
  input  logic [ADDR_WIDTH:0]     read_count,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_rd_en,
  input  logic [SAMPLE_WIDTH-1:0] mem_data,
  input  logic                    tx_busy,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  output logic                    busy,
  output logic                    done
);

  readback_state_t       state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic                  done_q, done_d;
  logic                  load;
  logic                  byte_done;
  logic                  last_byte;

  byte_serializer #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH)
  ) u_ser (
    .clock      (clock),
    .reset      (reset),
    .abort_i    (abort),
    .load_i     (load),
    .word_i     (mem_data),
    .tx_busy_i  (tx_busy),
    .tx_data_o  (tx_data),
    .tx_start_o (tx_start),
    .byte_done_o(byte_done),
    .last_byte_o(last_byte)
  );

  assign mem_addr  = addr_q;
  assign mem_rd_en = (state_q == READ);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (read_count == '0) begin
            state_d = FINISH;
          end else begin
            addr_d      = newest_addr;
            remaining_d = read_count;
            state_d     = READ;
          end
        end
      end
      READ:    state_d = MEMWAIT;
      MEMWAIT: begin
        load    = 1'b1;
        state_d = SEND;
      end
      // SEND covers the whole serializer handshake for the current sample.
      SEND: begin
        if (byte_done && last_byte) begin
          remaining_d = remaining_q - 1'b1;
          addr_d      = addr_q - 1'b1;
          state_d     = (remaining_d == '0) ? FINISH : READ;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
    end
    done_d = (state_q == FINISH) && !abort;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_capture_readback.sv
// Directed bench for capture_readback: 8-bit and 12-bit instances with RAM
// and UART models, a vector table plus hand-written multi-cycle sequences.
module tb_capture_readback;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, abort, never_busy;

  logic        start8, rd8, busy_tx8, txs8, busy8, done8;
  logic [9:0]  newest8, addr8;
  logic [10:0] count8;
  logic [7:0]  mdata8, txd8;

  logic        start12, rd12, busy_tx12, txs12, busy12, done12;
  logic [9:0]  newest12, addr12;
  logic [10:0] count12;
  logic [11:0] mdata12;
  logic [7:0]  txd12;

  capture_readback #(.SAMPLE_WIDTH(8), .ADDR_WIDTH(10)) u8 (
    .clock(clock), .reset(reset), .start(start8), .abort(abort),
    .newest_addr(newest8), .read_count(count8), .mem_addr(addr8),
    .mem_rd_en(rd8), .mem_data(mdata8), .tx_busy(busy_tx8),
    .tx_data(txd8), .tx_start(txs8), .busy(busy8), .done(done8)
  );

  capture_readback #(.SAMPLE_WIDTH(12), .ADDR_WIDTH(10)) u12 (
    .clock(clock), .reset(reset), .start(start12), .abort(abort),
    .newest_addr(newest12), .read_count(count12), .mem_addr(addr12),
    .mem_rd_en(rd12), .mem_data(mdata12), .tx_busy(busy_tx12),
    .tx_data(txd12), .tx_start(txs12), .busy(busy12), .done(done12)
  );

  logic [7:0]  ram8  [1024];
  logic [11:0] ram12 [1024];
  always @(posedge clock) begin
    if (rd8)  mdata8  <= ram8[addr8];
    if (rd12) mdata12 <= ram12[addr12];
  end

  // UART model: busy for 10 cycles starting the cycle after tx_start.
  int cnt8, cnt12;
  always @(posedge clock) begin
    if (reset) begin
      cnt8  <= 0;
      cnt12 <= 0;
    end else begin
      if (txs8 && !never_busy) cnt8 <= 10;
      else if (cnt8 != 0)      cnt8 <= cnt8 - 1;
      if (txs12 && !never_busy) cnt12 <= 10;
      else if (cnt12 != 0)      cnt12 <= cnt12 - 1;
    end
  end
  assign busy_tx8  = (cnt8 != 0);
  assign busy_tx12 = (cnt12 != 0);

  logic [7:0] q8[$];
  logic [7:0] q12[$];
  int nd8 = 0, nd12 = 0;
  always @(negedge clock) begin
    if (txs8)   q8.push_back(txd8);
    if (txs12)  q12.push_back(txd12);
    if (done8)  nd8++;
    if (done12) nd12++;
  end

  int nvec = 0, nfail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          wide;
    logic [9:0]  newest;
    logic [10:0] count;
    int          nbytes;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v, input int idx);
    int base, d0, n, dn;
    logic [63:0] act;
    base = v.wide ? q12.size() : q8.size();
    d0   = v.wide ? nd12 : nd8;
    @(negedge clock);
    if (v.wide) begin newest12 = v.newest; count12 = v.count; start12 = 1'b1; end
    else        begin newest8  = v.newest; count8  = v.count; start8  = 1'b1; end
    @(negedge clock);
    start8  = 1'b0;
    start12 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      dn = v.wide ? nd12 : nd8;
      if (dn != d0) break;
      @(negedge clock);
    end
    dn = v.wide ? nd12 : nd8;
    check($sformatf("v%0d done_seen", idx), 64'(dn != d0), 64'd1);
    repeat (3) @(negedge clock);
    n = (v.wide ? q12.size() : q8.size()) - base;
    check($sformatf("v%0d byte_count", idx), 64'(n), 64'(v.nbytes));
    for (int i = 0; i < v.nbytes; i++) begin
      act = 64'hx;
      if (i < n) act = 64'(v.wide ? q12[base+i] : q8[base+i]);
      check($sformatf("v%0d byte%0d", idx, i), act, 64'(v.exp[8*i +: 8]));
    end
    dn = v.wide ? nd12 : nd8;
    check($sformatf("v%0d done_pulses", idx), 64'(dn - d0), 64'd1);
    check($sformatf("v%0d busy_after", idx), 64'(v.wide ? busy12 : busy8), 64'd0);
  endtask

  initial begin
    int base, d0;
    vecs[0] = '{1'b0, 10'd5,  11'd3, 3, 64'hC3B2A1};
    vecs[1] = '{1'b0, 10'd1,  11'd4, 4, 64'h44332211};
    vecs[2] = '{1'b0, 10'd20, 11'd5, 5, 64'h5453525150};
    vecs[3] = '{1'b1, 10'd7,  11'd2, 4, 64'h01230ABC};
    vecs[4] = '{1'b0, 10'd3,  11'd1, 1, 64'hC3};

    ram8[5] = 8'hA1; ram8[4] = 8'hB2; ram8[3] = 8'hC3;
    ram8[1] = 8'h11; ram8[0] = 8'h22; ram8[1023] = 8'h33; ram8[1022] = 8'h44;
    for (int i = 0; i < 5; i++) ram8[20-i] = 8'(8'h50 + i);
    ram12[7] = 12'hABC; ram12[6] = 12'h123;

    reset = 1'b1; abort = 1'b0; never_busy = 1'b0;
    start8 = 1'b0; newest8 = '0; count8 = '0;
    start12 = 1'b0; newest12 = '0; count12 = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_outputs8", 64'({addr8, rd8, txd8, txs8, busy8, done8}), 64'd0);
    check("reset_outputs12", 64'({addr12, rd12, txd12, txs12, busy12, done12}), 64'd0);

    for (int k = 0; k < 5; k++) begin
      if (k != 2) run_vec(vecs[k], k);
    end

    // read_count = 0: FINISH next cycle, done the cycle after, no bytes.
    base = q8.size();
    d0   = nd8;
    @(negedge clock);
    count8 = '0; start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0;
    check("rc0 done_early", 64'(done8), 64'd0);
    check("rc0 busy_finish", 64'(busy8), 64'd1);
    @(negedge clock);
    check("rc0 done_at_2", 64'(done8), 64'd1);
    check("rc0 busy_after", 64'(busy8), 64'd0);
    repeat (5) @(negedge clock);
    check("rc0 no_bytes", 64'(q8.size() - base), 64'd0);
    check("rc0 done_once", 64'(nd8 - d0), 64'd1);

    // start while busy is ignored.
    base = q8.size();
    d0   = nd8;
    newest8 = 10'd5; count8 = 11'd3; start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0;
    repeat (20) @(negedge clock);
    newest8 = 10'd1; count8 = 11'd4; start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0;
    for (int i = 0; i < 3000 && nd8 == d0; i++) @(negedge clock);
    repeat (60) @(negedge clock);
    check("ignstart byte_count", 64'(q8.size() - base), 64'd3);
    check("ignstart done_once", 64'(nd8 - d0), 64'd1);

    // abort in DRAIN after the 2nd of 5 bytes.
    base = q8.size();
    d0   = nd8;
    newest8 = 10'd20; count8 = 11'd5; start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0;
    for (int i = 0; i < 3000 && q8.size() < base + 2; i++) @(negedge clock);
    check("abort reached_byte2", 64'(q8.size() - base), 64'd2);
    repeat (3) @(negedge clock);
    check("abort busy_before", 64'(busy8), 64'd1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort idle_next", 64'(busy8), 64'd0);
    repeat (40) @(negedge clock);
    check("abort no_more_bytes", 64'(q8.size() - base), 64'd2);
    check("abort no_done", 64'(nd8 - d0), 64'd0);
    run_vec(vecs[2], 2);

    // UART that never shows busy: timeout path, then reset mid-stream.
    never_busy = 1'b1;
    run_vec(vecs[0], 10);
    base = q8.size();
    d0   = nd8;
    @(negedge clock);
    newest8 = 10'd5; count8 = 11'd3; start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0;
    for (int i = 0; i < 3000 && q8.size() < base + 1; i++) @(negedge clock);
    repeat (2) @(negedge clock);
    check("rstmid busy_before", 64'(busy8), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check("rstmid outputs", 64'({addr8, rd8, txd8, txs8, busy8, done8}), 64'd0);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    check("rstmid no_more_bytes", 64'(q8.size() - base), 64'd1);
    check("rstmid no_done", 64'(nd8 - d0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/capture_readback.md
Name: capture_readback

Overview:
- Streams captured samples from the capture RAM to the host over the UART transmit path once a capture completes.
- It is the outbound counterpart of the command decoder: it turns stored sample words into the byte stream the host client expects.
- Reads newest-to-oldest, splits each sample into bytes LSB first, and paces every byte against the UART tx_busy handshake.
- Sits between the capture RAM read port and the transmit mux in front of the UART.

Parameters:
- SAMPLE_WIDTH, 8, bits per stored sample; bytes per sample BPS = ceil(SAMPLE_WIDTH/8).
- ADDR_WIDTH, 10, capture RAM address width; depth = 2**ADDR_WIDTH.

Ports:
- clock  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begin readback. Ignored unless state is IDLE.
- abort  input  1  level; forces return to IDLE on the next edge.
- newest_addr  input  ADDR_WIDTH  RAM address of the most recent sample; sampled on start.
- read_count  input  ADDR_WIDTH+1  number of samples to send, 0..depth; sampled on start.
- mem_addr  output  ADDR_WIDTH  RAM read address.
- mem_rd_en  output  1  RAM read enable.
- mem_data  input  SAMPLE_WIDTH  RAM read data, valid exactly 1 cycle after mem_rd_en.
- tx_busy  input  1  UART busy flag.
- tx_data  output  8  byte to transmit; held stable from tx_start until tx_busy falls.
- tx_start  output  1  one-cycle transmit request.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse on completion; not asserted on abort.

Behaviour:
- Reset values: mem_addr=0, mem_rd_en=0, tx_data=0, tx_start=0, busy=0, done=0, state=IDLE, all counters 0. Reset mid-stream discards the transfer; tx_start is low from the first cycle after reset.
- States: IDLE, READ, MEMWAIT, SEND, ACK, DRAIN, FINISH.
- IDLE
  - On start with read_count=0: go to FINISH; no bytes are sent.
  - On start with read_count>0: latch addr=newest_addr and remaining=read_count, then go to READ.
- READ: mem_addr=addr, mem_rd_en=1 for one cycle; go to MEMWAIT.
- MEMWAIT
  - Latch mem_data into shift register sreg, zero-extended to BPS*8 bits.
  - byte_idx=0; go to SEND.
- SEND: wait while tx_busy=1. When tx_busy=0: tx_data=sreg[7:0], tx_start=1 for exactly one cycle; go to ACK.
- ACK
  - Wait for tx_busy=1; tx_start is low.
  - If tx_busy is not seen within 4 cycles of tx_start, treat the byte as sent and proceed as from DRAIN. This prevents lockup on a UART that finishes instantly.
- DRAIN: wait for tx_busy=0, then:
  - If byte_idx<BPS-1: sreg>>=8, byte_idx++, go to SEND.
  - Otherwise: remaining--, addr=addr-1 modulo 2**ADDR_WIDTH (0 wraps to 2**ADDR_WIDTH-1).
  - If remaining is now 0: go to FINISH; otherwise go to READ.
- FINISH: done=1 for one cycle; go to IDLE.
- abort, in any non-IDLE state: next state is IDLE, tx_start=0, no done pulse. A byte already handed to the UART is allowed to complete on the line.
- abort has priority over start. start and abort in the same cycle: stay IDLE.
- Byte order: within a sample, LSB byte first; across samples, newest first. Total bytes sent = read_count*BPS.
- Throughput: minimum 2 cycles of overhead per sample (READ, MEMWAIT) plus the UART byte time.

Decomposition:
- Shared package acsp_pkg:
  - readback_state_t enum (IDLE..FINISH).
  - localparam function bytes_per_sample(SAMPLE_WIDTH).
  - ACK_TIMEOUT=4.
- Sub-module byte_serializer: owns sreg, byte_idx, the SEND/ACK/DRAIN handshake and the timeout. Interface: load, word, tx_* signals, byte_done, last_byte.
- The top FSM owns address, remaining count and done.

Test Plan:
- SAMPLE_WIDTH=8, newest_addr=5, read_count=3, RAM[5..3]=A1,B2,C3; UART model asserts busy 1 cycle after tx_start for 10 cycles. Expect bytes A1,B2,C3 in order, done pulses once, busy low the cycle after done.
- Wrap-around: newest_addr=1, read_count=4, RAM[1]=11, [0]=22, [1023]=33, [1022]=44. Expect bytes 11,22,33,44.
- SAMPLE_WIDTH=12, read_count=2, RAM[newest]=0xABC, RAM[newest-1]=0x123. Expect bytes BC,0A,23,01.
- read_count=0: done 2 cycles after start, tx_start never asserted. A start pulsed while busy=1 is ignored and the byte count is unchanged.
- abort asserted in DRAIN after the 2nd of 5 bytes. Expect state IDLE next cycle, no further tx_start, no done; a fresh start then sends the full 5 bytes.
- UART model that never raises tx_busy: each byte advances after the 4-cycle timeout; 3 samples complete with done. Assert a synchronous reset mid-stream: all outputs return to reset values on the next edge.
